// File: rtl/ps2_rx_deserializer.sv
// PS/2 device-to-host receiver: synchronizes and glitch-filters the raw lines,
// assembles 11-bit frames and emits each validated scan-code byte with a strobe.
module ps2_rx_deserializer #(
   parameter int unsigned FILTER_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       frame_error,
   output logic       busy
);

   localparam int FW = $clog2(FILTER_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   logic          clk_meta_q, clk_sync_q;
   logic          dat_meta_q, dat_sync_q;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          filt_clk_q, filt_clk_d;
   logic          fall_q, fall_d;

   state_e        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [7:0]    data_q, data_d;
   logic          data_en_q, data_en_d;
   logic          err_q, err_d;

   // Synchronizers idle at 1, the released-bus level, so reset never fakes an edge.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; blocking here would collapse the 2-FF chain into one flop.
      if (reset) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= PS2_CLK;
         clk_sync_q <= clk_meta_q;
         dat_meta_q <= PS2_DAT;
         dat_sync_q <= dat_meta_q;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output -- no latches.
      filt_cnt_d = '0;
      filt_clk_d = filt_clk_q;
      if (clk_sync_q != filt_clk_q) begin
         if (filt_cnt_q == FW'(FILTER_CYCLES - 1)) begin
            filt_clk_d = clk_sync_q;
         end else begin
            filt_cnt_d = filt_cnt_q + FW'(1);
         end
      end
      fall_d = filt_clk_q & ~filt_clk_d;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         filt_cnt_q <= '0;
         filt_clk_q <= 1'b1;
         fall_q     <= 1'b0;
      end else begin
         filt_cnt_q <= filt_cnt_d;
         filt_clk_q <= filt_clk_d;
         fall_q     <= fall_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      tmo_d     = tmo_q;
      data_d    = data_q;
      data_en_d = 1'b0;
      err_d     = 1'b0;

      if (fall_q) begin
         tmo_d = '0;
         case (state_q)
            S_IDLE: begin
               if (!dat_sync_q) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end
            end
            S_DATA: begin
               shift_d = {dat_sync_q, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  state_d = S_PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
            S_PARITY: begin
               parity_d = dat_sync_q;
               state_d  = S_STOP;
            end
            S_STOP: begin
               // Odd parity: data bits plus parity bit must hold an odd number of ones.
               if (dat_sync_q && (^{shift_q, parity_q})) begin
                  data_d    = shift_q;
                  data_en_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
         endcase
      end else if (state_q == S_IDLE) begin
         tmo_d = '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
         state_d = S_IDLE;
         shift_d = '0;
         err_d   = 1'b1;
         tmo_d   = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tmo_q     <= '0;
         data_q    <= '0;
         data_en_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         tmo_q     <= tmo_d;
         data_q    <= data_d;
         data_en_q <= data_en_d;
         err_q     <= err_d;
      end
   end

   assign received_data    = data_q;
   assign received_data_en = data_en_q;
   assign frame_error      = err_q;
   assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_rx_deserializer.sv
// Bench for ps2_rx_deserializer: directed and random PS/2 frames checked every
// cycle against a frame-level model of expected strobes, data and busy windows.
module tb_ps2_rx_deserializer;

   localparam int F   = 4;
   localparam int T   = 2000;
   localparam int H   = 200;
   localparam int LAT = 3 + F;

   typedef struct {
      int         t_start;
      int         t_end;
      bit         ok;
      logic [7:0] data;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] received_data;
   logic       received_data_en;
   logic       frame_error;
   logic       busy;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         en_cnt = 0;
   int         err_cnt = 0;
   int         last_en_cyc = -1;
   logic [7:0] en_log[$];
   frame_t     fq[$];
   logic [7:0] exp_data = 8'h00;

   ps2_rx_deserializer #(
      .FILTER_CYCLES (F),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .CLOCK_50        (clk),
      .reset           (rst),
      .PS2_CLK         (ps2_clk),
      .PS2_DAT         (ps2_dat),
      .received_data   (received_data),
      .received_data_en(received_data_en),
      .frame_error     (frame_error),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Falling edge i lands h*(2i+1) cycles after entry; a glitch keeps that timing.
   task automatic send_bits(input logic [10:0] bits, input int nfalls, input int h,
                            input int glitch_at);
      for (int i = 0; i < nfalls; i++) begin
         ps2_dat = bits[i];
         if (i == glitch_at) begin
            tick(h / 2);
            ps2_clk = 1'b0;
            tick(2);
            ps2_clk = 1'b1;
            tick(h - h / 2 - 2);
         end else begin
            tick(h);
         end
         ps2_clk = 1'b0;
         tick(h);
         ps2_clk = 1'b1;
      end
   endtask

   function automatic logic [10:0] make_bits(input logic [7:0] b, input bit par_ok,
                                             input bit stop_ok);
      logic p;
      p = (~^b) ^ ~par_ok;
      return {stop_ok, p, b, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                             input int h, input int glitch_at);
      frame_t f;
      int c0;
      c0        = cyc;
      f.t_start = c0 + h + LAT;
      f.t_end   = c0 + 21 * h + LAT;
      f.ok      = par_ok && stop_ok;
      f.data    = b;
      fq.push_back(f);
      send_bits(make_bits(b, par_ok, stop_ok), 11, h, glitch_at);
      ps2_dat = 1'b1;
   endtask

   // Sends only the first nfalls bits; the receiver must time out on its own.
   task automatic send_trunc(input logic [7:0] b, input int nfalls, input int h);
      frame_t f;
      int c0;
      c0        = cyc;
      f.t_start = c0 + h + LAT;
      f.t_end   = c0 + h * (2 * nfalls - 1) + LAT + T;
      f.ok      = 1'b0;
      f.data    = b;
      fq.push_back(f);
      send_bits(make_bits(b, 1'b1, 1'b1), nfalls, h, -1);
      ps2_dat = 1'b1;
   endtask

   initial begin : compare
      logic e_en, e_err, e_busy;
      forever begin
         @(negedge clk);
         e_en   = 1'b0;
         e_err  = 1'b0;
         e_busy = 1'b0;
         if (rst) begin
            exp_data = 8'h00;
         end else if (fq.size() > 0) begin
            if (cyc >= fq[0].t_start && cyc < fq[0].t_end) e_busy = 1'b1;
            if (cyc == fq[0].t_end) begin
               if (fq[0].ok) begin
                  e_en     = 1'b1;
                  exp_data = fq[0].data;
               end else begin
                  e_err = 1'b1;
               end
               void'(fq.pop_front());
            end
         end
         check("cyc_en", received_data_en, e_en);
         check("cyc_err", frame_error, e_err);
         check("cyc_busy", busy, e_busy);
         check("cyc_data", received_data, exp_data);
         if (received_data_en) begin
            en_cnt++;
            en_log.push_back(received_data);
            last_en_cyc = cyc;
         end
         if (frame_error) err_cnt++;
      end
   end

   initial begin : watchdog
      #950000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stimulus
      int e0, r0, c0;
      tick(3);
      check("rst_data", received_data, 8'h00);
      check("rst_en", received_data_en, 1'b0);
      check("rst_err", frame_error, 1'b0);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      tick(20);

      // 1: single good frame, exact strobe latency after the raw stop-bit edge
      e0 = en_cnt; r0 = err_cnt; c0 = cyc;
      send_frame(8'h1D, 1'b1, 1'b1, H, -1);
      tick(H);
      check("t1_data", received_data, 8'h1D);
      check("t1_en_count", en_cnt - e0, 1);
      check("t1_err_count", err_cnt - r0, 0);
      check("t1_latency", last_en_cyc, c0 + 21 * H + 7);
      check("t1_busy", busy, 1'b0);

      // 2: back-to-back break prefix and scan code
      e0 = en_cnt;
      send_frame(8'hF0, 1'b1, 1'b1, H, -1);
      send_frame(8'h44, 1'b1, 1'b1, H, -1);
      tick(H);
      check("t2_en_count", en_cnt - e0, 2);
      check("t2_first", en_log[en_log.size() - 2], 8'hF0);
      check("t2_second", en_log[en_log.size() - 1], 8'h44);

      // 3: bad parity is discarded and the previous byte is held
      e0 = en_cnt; r0 = err_cnt;
      send_frame(8'h1B, 1'b0, 1'b1, H, -1);
      tick(H);
      check("t3_err_count", err_cnt - r0, 1);
      check("t3_en_count", en_cnt - e0, 0);
      check("t3_data_held", received_data, 8'h44);

      // 4: short clock glitches while idle (data low) and inside a data bit
      e0 = en_cnt; r0 = err_cnt;
      ps2_dat = 1'b0;
      tick(20);
      ps2_clk = 1'b0;
      tick(2);
      ps2_clk = 1'b1;
      tick(50);
      check("t4_idle_glitch_busy", busy, 1'b0);
      ps2_dat = 1'b1;
      tick(20);
      send_frame(8'h4B, 1'b1, 1'b1, H, 3);
      tick(H);
      check("t4_data", received_data, 8'h4B);
      check("t4_en_count", en_cnt - e0, 1);
      check("t4_err_count", err_cnt - r0, 0);

      // 5: frame stops after four data bits and must time out
      e0 = en_cnt; r0 = err_cnt;
      send_trunc(8'hA5, 5, H);
      tick(T + 20);
      check("t5_err_count", err_cnt - r0, 1);
      check("t5_en_count", en_cnt - e0, 0);
      check("t5_busy", busy, 1'b0);
      check("t5_data_held", received_data, 8'h4B);
      send_frame(8'h1D, 1'b1, 1'b1, H, -1);
      tick(H);
      check("t5_recover", received_data, 8'h1D);

      // 6: reset mid-frame clears everything at once
      send_trunc(8'h5A, 5, H);
      tick(10);
      rst = 1'b1;
      fq.delete();
      #1;
      check("t6_rst_data", received_data, 8'h00);
      check("t6_rst_en", received_data_en, 1'b0);
      check("t6_rst_err", frame_error, 1'b0);
      check("t6_rst_busy", busy, 1'b0);
      tick(3);
      rst = 1'b0;
      tick(20);
      e0 = en_cnt;
      send_frame(8'h44, 1'b1, 1'b1, H, -1);
      tick(H);
      check("t6_data", received_data, 8'h44);
      check("t6_en_count", en_cnt - e0, 1);

      // Random frames: mixed validity, speeds, gaps and clock glitches
      for (int k = 0; k < 12; k++) begin
         logic [7:0] b;
         int m, h, g;
         b = 8'($urandom);
         m = $urandom_range(0, 9);
         h = $urandom_range(20, 100);
         g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : -1;
         send_frame(b, m != 0, m != 1, h, g);
         tick($urandom_range(0, 40));
      end
      tick(200);
      check("all_frames_seen", fq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
